// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
// Optional feature macro used by div_arbiter: DIV_ARB_PERF_EN.
package div_arb_pkg;

   // Arbiter sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   // Width of each per-requester grant counter
   localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/div_arb_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit
// searching upward from ptr+1 with wrap-around.
module div_arb_rr_pick
   import div_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_valid
);

   logic [ID_W-1:0] cand;
   logic            found;

   // Walk the requesters in priority order starting just after ptr
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand      = '0;
      found     = 1'b0;
      any_valid = |req;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative signed divider among NUM_REQ
// requesters. One request is in flight at a time; the response carries the
// index of the requester that owns it.
// Optional feature macro: DIV_ARB_PERF_EN (grant and busy counters).
module div_arbiter
   import div_arb_pkg::*;
#(
   parameter  int NUM_REQ        = 4,
   parameter  int DIVIDEND_WIDTH = 32,
   parameter  int DIVISOR_WIDTH  = 32,
   localparam int ID_W           = $clog2(NUM_REQ)
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_numerator,
   input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_denominator,
   output logic                              div_start,
   output logic [DIVIDEND_WIDTH-1:0]         div_numerator,
   output logic [DIVISOR_WIDTH-1:0]          div_denominator,
   input  logic [DIVIDEND_WIDTH-1:0]         div_quotient,
   input  logic [DIVISOR_WIDTH-1:0]          div_remainder,
   input  logic                              div_error,
   input  logic                              div_done,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [ID_W-1:0]                   rsp_id,
   output logic [DIVIDEND_WIDTH-1:0]         rsp_quotient,
   output logic [DIVISOR_WIDTH-1:0]          rsp_remainder,
   output logic                              rsp_error
`ifdef DIV_ARB_PERF_EN
   ,
   output logic [NUM_REQ*PERF_CNT_W-1:0]     perf_grant_cnt,
   output logic [31:0]                       perf_busy_cnt
`endif
);

   arb_state_t state_reg, state_next;

   logic [NUM_REQ-1:0]        grant;
   logic [ID_W-1:0]           grant_idx;
   logic [ID_W-1:0]           ptr_reg;   // last granted index, doubles as owner id
   logic                      any_valid;
   logic                      accept;

   logic [DIVIDEND_WIDTH-1:0] num_arr [NUM_REQ];
   logic [DIVISOR_WIDTH-1:0]  den_arr [NUM_REQ];

   // Unpack the per-requester operand slices
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign num_arr[gi] = req_numerator[gi*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
      assign den_arr[gi] = req_denominator[gi*DIVISOR_WIDTH +: DIVISOR_WIDTH];
   end

   div_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req       (req_valid),
      .ptr       (ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_valid (any_valid)
   );

   // Grants are offered only in IDLE, and never while reset is asserted
   assign accept    = reset && (state_reg == IDLE) && any_valid;
   assign req_ready = accept ? grant : '0;
   assign div_start = (state_reg == ISSUE);

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept)    state_next = ISSUE;
         ISSUE:                  state_next = WAIT;
         WAIT:    if (div_done)  state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Latch operands and owner index on accept; held until the next accept
   // so the divider can re-read them during its sign fix-up
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div_numerator   <= '0;
         div_denominator <= '0;
         ptr_reg         <= ID_W'(NUM_REQ - 1);
      end else if (accept) begin
         div_numerator   <= num_arr[grant_idx];
         div_denominator <= den_arr[grant_idx];
         ptr_reg         <= grant_idx;
      end
   end

   // Capture the divider result and run the response handshake
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
         rsp_error     <= 1'b0;
      end else if (state_reg == WAIT && div_done) begin
         rsp_valid     <= 1'b1;
         rsp_id        <= ptr_reg;
         rsp_quotient  <= div_quotient;
         rsp_remainder <= div_remainder;
         rsp_error     <= div_error;
      end else if (state_reg == RESP && rsp_ready) begin
         rsp_valid     <= 1'b0;
      end
   end

`ifdef DIV_ARB_PERF_EN
   // Per-requester saturating accept counters
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf_grant
      logic [PERF_CNT_W-1:0] cnt_reg;
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            cnt_reg <= '0;
         end else if (accept && grant[gi] && (cnt_reg != {PERF_CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
      assign perf_grant_cnt[gi*PERF_CNT_W +: PERF_CNT_W] = cnt_reg;
   end

   // Wrapping count of cycles spent driving the divider
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_busy_cnt <= '0;
      end else if (state_reg == ISSUE || state_reg == WAIT) begin
         perf_busy_cnt <= perf_busy_cnt + 32'd1;
      end
   end
`else
   // Performance counters not built
`endif

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Round-robin scheduler sharing one iterative signed divider (divider_work-style, start/done handshake) among NUM_REQ requesters, e.g. per-channel gain normalisation in the FM demod chain.
- Accepts one request at a time, latches its operands, sequences the divider, then returns the result tagged with the requester index.
- Sits between the channel datapaths and the single divider instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIVIDEND_WIDTH, 32, numerator/quotient width, two's complement.
- DIVISOR_WIDTH, 32, denominator/remainder width, two's complement.
- ID_W, $clog2(NUM_REQ), requester index width (derived localparam).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- req_numerator  in  NUM_REQ*DIVIDEND_WIDTH  packed numerators; requester i at slice i.
- req_denominator  in  NUM_REQ*DIVISOR_WIDTH  packed denominators.
- div_start  out  1  one-cycle start pulse to divider.
- div_numerator  out  DIVIDEND_WIDTH  latched numerator to divider.
- div_denominator  out  DIVISOR_WIDTH  latched denominator to divider.
- div_quotient  in  DIVIDEND_WIDTH  divider quotient.
- div_remainder  in  DIVISOR_WIDTH  divider remainder.
- div_error  in  1  divider divide-by-zero flag.
- div_done  in  1  divider one-cycle completion pulse.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_quotient  out  DIVIDEND_WIDTH  quotient.
- rsp_remainder  out  DIVISOR_WIDTH  remainder.
- rsp_error  out  1  divide-by-zero.

Behaviour:
- Reset values: every output 0 (req_ready, div_start, div_*, rsp_*); rr pointer = NUM_REQ-1, so requester 0 has first priority; state IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from pointer+1 with wrap.
  - Assert req_ready for that bit only, combinationally, in this cycle. A request is accepted when req_valid[i] & req_ready[i].
  - On accept, latch that requester's operands into div_numerator/div_denominator, latch the index, set pointer = index, and go to ISSUE.
- ISSUE: div_start = 1 for exactly one cycle, then go to WAIT.
- WAIT:
  - div_numerator/div_denominator stay stable from ISSUE until div_done, because the divider reads its operand inputs again for sign fix-up in its final state.
  - On div_done, register quotient, remainder and error into the rsp_* outputs, set rsp_valid, and go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid & !rsp_ready.
  - On rsp_ready, clear rsp_valid and go to IDLE.
  - No new request is accepted in the cycle rsp_ready is high.
- Latency: accept at cycle T → div_start at T+1 → rsp_valid the cycle after div_done. The minimum turnaround of the arbiter itself is 4 cycles plus the divider time.
- req_ready is 0 outside IDLE. A requester deasserting req_valid before being granted is legal; a request is never lost once accepted.
- div_done seen outside WAIT is ignored.
- div_error passes through unchanged. Quotient and remainder are forwarded as the divider provides them, with no arbitration-side arithmetic.
- Reset mid-operation aborts everything with no response issued. The divider shares the same top-level reset, inverted to its own active-high reset, so both restart together.
- Fairness: with all requesters continuously valid, the grant order is 0,1,...,NUM_REQ-1,0,...

Optional Feature:
- Macro: DIV_ARB_PERF_EN.
- Defined: adds output perf_grant_cnt (NUM_REQ*16 bits), a per-requester saturating count of accepts, and output perf_busy_cnt (32 bits), a wrapping count of cycles in ISSUE/WAIT. Both counters clear on reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package div_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP) as logic [1:0];
  - perf counter width constant PERF_CNT_W = 16.
- One sub-module, div_arb_rr_pick:
  - purely combinational;
  - inputs: req vector, pointer;
  - outputs: one-hot grant, grant index, any-valid.

Test Plan:
- Req0 100/7 with rsp_ready=1 → rsp_id=0, quotient 14, remainder 2, error 0; div_start high exactly one cycle.
- Req2 −100/7 → quotient −14 (0xFFFFFFF2), remainder −2; Req1 5/0 → rsp_error=1, rsp_id=1.
- All 4 req_valid held from reset, each 64/8 → grants and rsp_id in order 0,1,2,3,0; each response has quotient 8, remainder 0.
- rsp_ready held low 10 cycles after rsp_valid → rsp_* stable throughout; req_ready stays 0; next accept only after the handshake.
- reset pulled low while in WAIT → all outputs 0 next edge; after release, Req3 9/4 → quotient 2, remainder 1, rsp_id=3.
- Spurious div_done pulse in IDLE → no rsp_valid. With DIV_ARB_PERF_EN, 5 accepts on req1 → perf_grant_cnt[1]=5.
